// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the pd4 instruction fetch stage.
//   FETCH_RESET_PC  default program counter loaded on reset
//   INST_NOP        canonical no-op encoding (addi x0, x0, 0)
//   PC_STEP         byte distance between sequential instructions
//   fetch_entry_t   one buffered fetch: {pc, inst}
//   align_pc()      forces a byte address onto a word boundary
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0100_0000;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
  localparam logic [31:0] PC_STEP        = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; the two low address bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small instruction buffer between fetch and decode.
//   clock, reset  core clock, asynchronous active-high reset
//   push          write wr_entry at the write pointer
//   pop           retire the head entry
//   flush         discard everything and rewind both pointers (wins over push/pop)
//   wr_entry      entry to store
//   rd_entry      head entry, read combinationally from storage
//   count         number of occupied entries, 0..DEPTH
// The producer guarantees push is only raised when there is room (or a pop
// frees a slot in the same cycle), and pop only when count != 0.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             rd_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [PW-1:0] PONE_C = PW'(1);

  fetch_entry_t         mem_r [DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        count_next_s;

  // Occupancy update; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_next_s = count_r;
    if (flush) begin
      count_next_s = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next_s = count_r + ONE_C;
        2'b01:   count_next_s = count_r - ONE_C;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Pointer, occupancy and storage registers. DEPTH is a power of two, so
  // the pointers wrap naturally at their width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      count_r <= count_next_s;
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push) begin
          mem_r[wr_ptr_r] <= wr_entry;
          wr_ptr_r        <= wr_ptr_r + PONE_C;
        end
        if (pop) begin
          rd_ptr_r <= rd_ptr_r + PONE_C;
        end
      end
    end
  end

  assign rd_entry = mem_r[rd_ptr_r];
  assign count    = count_r;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pd4 instruction fetch stage.
// Holds the PC, drives the instruction memory address, and buffers each
// returned word with its PC in fetch_fifo for decode.
//   clock, reset          core clock, asynchronous active-high reset
//   redirect_valid/pc     branch/jump target from execute; flushes the buffer
//   imem_addr             instruction memory byte address (= pc register)
//   imem_data             combinational read data for imem_addr
//   imem_read_write       tied 0 (fetch never writes)
//   imem_data_in          tied 0
//   inst_valid/ready      decode handshake on the buffer head
//   inst_out, inst_pc     head instruction word and its PC
//   misalign_err          one-cycle pulse after a redirect with pc[1:0] != 0
// Build option: define FETCH_MISALIGN_CHK_EN to enable misalign_err;
// otherwise it is tied to 0 and the low target bits are dropped silently.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        imem_read_write,
  output logic [31:0] imem_data_in,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        misalign_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_r;
  logic [31:0]   pc_next_s;
  logic [CW-1:0] count_s;
  logic          pop_s;
  logic          push_s;
  fetch_entry_t  wr_entry_s;
  fetch_entry_t  rd_entry_s;

  assign inst_valid = (count_s != '0);
  assign pop_s      = inst_valid & inst_ready;
  // A full buffer can still accept when decode frees the head this cycle.
  assign push_s     = ~redirect_valid & ((count_s < DEPTH_C) | pop_s);

  assign wr_entry_s.pc   = pc_r;
  assign wr_entry_s.inst = imem_data;

  // Next PC: redirect first, then sequential advance on capture, else hold.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_valid) begin
      pc_next_s = align_pc(redirect_pc);
    end else if (push_s) begin
      pc_next_s = pc_r + PC_STEP;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Program counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_r;

  // Flags a redirect target that was not word aligned, for one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end
  end

  assign misalign_err = misalign_r;
`else
  assign misalign_err = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (redirect_valid),
    .wr_entry (wr_entry_s),
    .rd_entry (rd_entry_s),
    .count    (count_s)
  );

  assign imem_addr       = pc_r;
  assign imem_read_write = 1'b0;
  assign imem_data_in    = 32'h0000_0000;
  assign inst_out        = rd_entry_s.inst;
  assign inst_pc         = rd_entry_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// The instruction memory returns word k = 32'hA000_0000 + k for the address
// RESET_PC + 4*k (modulo 2^32), so each word identifies its fetch address.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0100_0000;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .imem_read_write (imem_read_write),
    .imem_data_in    (imem_data_in),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .misalign_err    (misalign_err)
  );

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - RST_PC;
    return 32'hA000_0000 + (off >> 2);
  endfunction

  assign imem_data = word_at(imem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = ready;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    // still before the first post-reset edge
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, RST_PC); end
    checks++; if (inst_out !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_head got %h/%h want 0/0", inst_out, inst_pc); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b want 0", misalign_err); end
    checks++; if (imem_read_write !== 1'b0 || imem_data_in !== 32'h0) begin errors++; $display("FAIL reset_wr got %0b/%h want 0/0", imem_read_write, imem_data_in); end
    checks++; if (dut.count_s !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", dut.count_s); end
  endtask

  task automatic test_stream();
    // inst_ready held high: one instruction per cycle, count stays 1
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC + 32'(4 * k) || inst_out !== 32'hA000_0000 + 32'(k)) begin
        errors++; $display("FAIL stream_%0d got v=%0b pc=%h w=%h want v=1 pc=%h w=%h", k, inst_valid, inst_pc, inst_out, RST_PC + 32'(4 * k), 32'hA000_0000 + 32'(k));
      end
      checks++; if (dut.count_s !== 2'd1) begin errors++; $display("FAIL stream_count_%0d got %0d want 1", k, dut.count_s); end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++; if (dut.count_s !== ((c == 1) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL stall_count_%0d got %0d want %0d", c, dut.count_s, (c == 1) ? 1 : 2); end
      checks++; if (inst_pc !== RST_PC || inst_out !== 32'hA000_0000) begin errors++; $display("FAIL stall_head_%0d got %h/%h want %h/a0000000", c, inst_pc, inst_out, RST_PC); end
      if (c >= 2) begin
        checks++; if (imem_addr !== RST_PC + 32'd8) begin errors++; $display("FAIL stall_addr_%0d got %h want %h", c, imem_addr, RST_PC + 32'd8); end
      end
    end
    inst_ready = 1'b1;
    // the head k=0 retires at the next edge; k=1..3 must follow in order
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC + 32'(4 * k) || inst_out !== 32'hA000_0000 + 32'(k)) begin
        errors++; $display("FAIL stall_release_%0d got v=%0b pc=%h w=%h want pc=%h", k, inst_valid, inst_pc, inst_out, RST_PC + 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    inst_ready = 1'b0;
    step();
    checks++; if (dut.count_s !== 2'd2) begin errors++; $display("FAIL redir_pre_count got %0d want 2", dut.count_s); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0040;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h0100_0040) begin errors++; $display("FAIL redir_flush got v=%0b a=%h want v=0 a=01000040", inst_valid, imem_addr); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0100_0040 || inst_out !== 32'hA000_0010) begin errors++; $display("FAIL redir_target got v=%0b pc=%h w=%h want 1/01000040/a0000010", inst_valid, inst_pc, inst_out); end
  endtask

  task automatic test_redirect_pop();
    // head valid and inst_ready high: a pop and a push would both happen
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0080;
    step();
    redirect_valid = 1'b0;
    checks++; if (dut.count_s !== 2'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rpop_count got %0d v=%0b want 0/0", dut.count_s, inst_valid); end
    checks++; if (imem_addr !== 32'h0100_0080) begin errors++; $display("FAIL rpop_addr got %h want 01000080", imem_addr); end
    step();
    checks++; if (inst_pc !== 32'h0100_0080 || inst_out !== 32'hA000_0020) begin errors++; $display("FAIL rpop_first got %h/%h want 01000080/a0000020", inst_pc, inst_out); end
    step();
    checks++; if (inst_pc !== 32'h0100_0084 || inst_out !== 32'hA000_0021) begin errors++; $display("FAIL rpop_second got %h/%h want 01000084/a0000021", inst_pc, inst_out); end
  endtask

  task automatic test_misalign();
    logic exp_err;
`ifdef FETCH_MISALIGN_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0046;
    step();
    redirect_valid = 1'b0;
    checks++; if (misalign_err !== exp_err) begin errors++; $display("FAIL misalign_pulse got %0b want %0b", misalign_err, exp_err); end
    checks++; if (imem_addr !== 32'h0100_0044) begin errors++; $display("FAIL misalign_addr got %h want 01000044", imem_addr); end
    step();
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL misalign_clear got %0b want 0", misalign_err); end
    checks++; if (inst_pc !== 32'h0100_0044 || inst_valid !== 1'b1) begin errors++; $display("FAIL misalign_pc got %h v=%0b want 01000044/1", inst_pc, inst_valid); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
    step();
    checks++; if (imem_addr !== 32'h0000_0000 || inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_next got a=%h pc=%h want 0/fffffffc", imem_addr, inst_pc); end
    step();
    checks++; if (inst_pc !== 32'h0000_0000 || inst_out !== 32'hDFC0_0000) begin errors++; $display("FAIL wrap_zero got %h/%h want 0/dfc00000", inst_pc, inst_out); end
  endtask

  task automatic test_reset_mid();
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got v=%0b want 1", inst_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0 || imem_addr !== RST_PC) begin errors++; $display("FAIL midrst_async got v=%0b a=%h want 0/%h", inst_valid, imem_addr, RST_PC); end
    checks++; if (inst_out !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL midrst_head got %h/%h want 0/0", inst_out, inst_pc); end
    step();
    reset = 1'b0;
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC) begin errors++; $display("FAIL midrst_restart got v=%0b pc=%h want 1/%h", inst_valid, inst_pc, RST_PC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the pd4 core. Holds the program counter, drives the instruction memory's address port, and captures each returned word with its PC into a small FIFO. The FIFO feeds decode over a valid/ready handshake. Branch and jump redirects from execute flush the FIFO and restart fetch at the target.

## Interface
- RESET_PC, 32'h0100_0000, PC value loaded on reset
- DEPTH, 2, instruction buffer entries; power of two, ≥2
- clock  in  1  core clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  32  redirect target
- imem_addr  out  32  instruction memory byte address; equals the pc register
- imem_data  in  32  instruction memory read data; combinational from imem_addr
- imem_read_write  out  1  constant 0; fetch never writes
- imem_data_in  out  32  constant 0
- inst_valid  out  1  FIFO head holds a valid instruction
- inst_ready  in  1  decode accepts the head this cycle
- inst_out  out  32  head instruction word
- inst_pc  out  32  head instruction PC
- misalign_err  out  1  one-cycle pulse on a misaligned redirect; only meaningful with the macro enabled

## Operation
- Reset values:
  - pc = RESET_PC
  - count = 0, read/write pointers = 0
  - inst_valid = 0, inst_out = 0, inst_pc = 0
  - misalign_err = 0
- pop = inst_valid & inst_ready.
- push = !redirect_valid & (count < DEPTH | pop).
- On push:
  - write {pc, imem_data} at the write pointer
  - pc <= pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0
- FIFO full and no pop: pc holds and no capture occurs; imem_addr stays stable.
- Redirect:
  - has priority over push and pop
  - all entries are discarded, including one handshaked in the same cycle; execute owns squashing of that instruction
  - count <= 0, pointers <= 0, pc <= {redirect_pc[31:2], 2'b00}
- Simultaneous push and pop with count = DEPTH: legal, and count is unchanged.
- Pointers wrap modulo DEPTH.
- count is $clog2(DEPTH)+1 bits wide.
- inst_valid = (count != 0).
- inst_out and inst_pc are read directly from the head entry, with no added register stage.
- Reset asserted mid-operation: the FIFO is emptied and pc returns to RESET_PC asynchronously; there is no partial state.

## Timing
- Fetch latency: a PC presented on imem_addr in cycle N appears at the FIFO head (inst_valid = 1) in cycle N+1.
- Throughput: with inst_ready held high, one instruction per cycle and steady-state count = 1.
- Redirect asserted in cycle N:
  - imem_addr = target in cycle N+1
  - target instruction valid in cycle N+2
- After reset release: first inst_valid in the second cycle, at inst_pc = RESET_PC.
- inst_out and inst_pc are stable while inst_valid = 1 and inst_ready = 0.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - a redirect with redirect_pc[1:0] != 0 sets misalign_err high for exactly the next cycle (registered)
  - the redirect still takes effect with the low bits cleared
- FETCH_MISALIGN_CHK_EN undefined: the low bits are dropped silently and misalign_err is tied to 0.

## Structure
- fetch_pkg holds:
  - RESET_PC default
  - INST_NOP = 32'h0000_0013
  - PC_STEP = 4
  - packed struct fetch_entry_t {pc[31:0], inst[31:0]}
- One sub-module: fetch_fifo
  - parameterised DEPTH; stores fetch_entry_t
  - ports: push, pop, flush, count
  - fetch_unit contains only the PC logic and the glue around it.

## Test plan
- Reset, inst_ready = 1, memory holds word k = 32'hA000_0000+k → inst_pc = 0x0100_0000, 0x0100_0004, … with matching words, one per cycle from cycle 2.
- inst_ready = 0 for 5 cycles → count saturates at 2; imem_addr freezes at RESET_PC+8; inst_pc stays 0x0100_0000; no word lost after release.
- Redirect to 0x0100_0040 with 2 entries buffered → inst_valid = 0 in the next cycle; the following valid instruction has inst_pc = 0x0100_0040.
- Redirect in the same cycle as a pop, with a push-eligible FIFO → redirect wins; count = 0; no stale PC appears afterward.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x0100_0046 → misalign_err = 1 for one cycle; next inst_pc = 0x0100_0044. Without the macro, misalign_err stays 0.
- pc = 32'hFFFF_FFFC via redirect → next fetch address wraps to 0. Reset asserted mid-stream → inst_valid drops immediately; imem_addr = RESET_PC.
